// File: rtl/lupa_cfg_pkg.sv
// rtl/lupa_cfg_pkg.sv - shared types and constants for the LUPA sensor configuration sequencer
package lupa_cfg_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_NEXT
  } state_t;

  // Power-on contents of the shadow register table, address 0 first.
  localparam logic [DATA_W-1:0] DEFAULT_TABLE [16] = '{
    12'h029, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
    12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB
  };

  function automatic logic [ADDR_W+DATA_W-1:0] make_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/lupa_spi_frame_tx.sv
// rtl/lupa_spi_frame_tx.sv - serializes one 16-bit frame onto the sensor SPI pins
// A setup phase of CLK_DIV cycles precedes 16 high/low spi_clk periods; data moves on the falling edge.
module lupa_spi_frame_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock_40,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] frame,
  output logic        spi_clk,
  output logic        spi_en,
  output logic        spi_dat,
  output logic        frame_done
);

  logic        r_active;
  logic        r_setup;
  logic        r_clk;
  logic [3:0]  r_div;
  logic [3:0]  r_bit;
  logic [15:0] r_shift;
  logic        w_div_end;

  assign w_div_end  = (r_div == 4'(CLK_DIV - 1));
  assign frame_done = r_active & ~r_setup & ~r_clk & w_div_end & (r_bit == 4'd15);

  assign spi_en  = ~r_active;
  assign spi_clk = r_clk;
  assign spi_dat = r_active & r_shift[15];

  always_ff @(posedge clock_40 or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_setup  <= 1'b0;
      r_clk    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else if (load) begin
      r_active <= 1'b1;
      r_setup  <= 1'b1;
      r_clk    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= frame;
    end else if (r_active) begin
      r_div <= w_div_end ? 4'd0 : r_div + 4'd1;
      if (w_div_end) begin
        if (r_setup) begin
          r_setup <= 1'b0;
          r_clk   <= 1'b1;
        end else if (r_clk) begin
          // Next bit appears while spi_clk is low so the sensor sees stable data on the rise.
          r_clk   <= 1'b0;
          r_shift <= {r_shift[14:0], 1'b0};
        end else if (r_bit == 4'd15) begin
          r_active <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
          r_clk <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lupa_cfg_sequencer.sv
// rtl/lupa_cfg_sequencer.sv - uploads the shadow register table 0..nrg to the sensor over SPI
// Optional LUPA_CFG_DIRTY_ONLY_EN: only addresses written since their last upload are sent.
module lupa_cfg_sequencer
  import lupa_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic              clock_40,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] nrg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              spi_clk,
  output logic              spi_en,
  output logic              spi_dat,
  output logic              busy,
  output logic              cfg_done,
  output logic [ADDR_W-1:0] cur_addr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [3:0]        r_cnt;
  logic              r_cfg_done;
  logic [DATA_W-1:0] r_table [16];
  logic              w_load;
  logic              w_frame_done;
  logic [15:0]       w_frame;
  logic              w_found;
  logic [ADDR_W-1:0] w_found_addr;

  assign busy     = (r_state != ST_IDLE);
  assign cfg_done = r_cfg_done;
  assign cur_addr = r_addr;
  assign w_frame  = make_frame(r_addr, r_table[r_addr]);

`ifdef LUPA_CFG_DIRTY_ONLY_EN
  logic [15:0]       r_dirty;
  logic [ADDR_W-1:0] w_last;

  assign w_last = (r_state == ST_IDLE) ? nrg : r_last;

  // Lowest dirty address above the one just sent (from 0 when idle), bounded by the last index.
  always_comb begin
    w_found      = 1'b0;
    w_found_addr = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_dirty[i] && (i <= int'(w_last)) && ((r_state == ST_IDLE) || (i > int'(r_addr)))) begin
        w_found      = 1'b1;
        w_found_addr = ADDR_W'(i);
      end
    end
  end

  // A write landing on the LOAD cycle keeps its bit so the new value goes out next upload.
  always_ff @(posedge clock_40 or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= '0;
    end else begin
      if (r_state == ST_LOAD) r_dirty[r_addr] <= 1'b0;
      if (wr_en) r_dirty[wr_addr] <= 1'b1;
    end
  end
`else
  always_comb begin
    w_found      = 1'b1;
    w_found_addr = '0;
    if (r_state == ST_NEXT) begin
      w_found      = (r_addr < r_last);
      w_found_addr = r_addr + 4'd1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = w_found ? ST_LOAD : ST_NEXT;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SETUP;
      end
      ST_SETUP: if (r_cnt == 4'(CLK_DIV - 1)) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_frame_done) w_state_nxt = ST_GAP;
      ST_GAP:   if (r_cnt == 4'(GAP_CYC - 1)) w_state_nxt = ST_NEXT;
      ST_NEXT:  w_state_nxt = w_found ? ST_LOAD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_40 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_SETUP) || (r_state == ST_GAP)) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_cfg_done <= 1'b0;
        r_last     <= nrg;
        r_addr     <= w_found_addr;
      end
      if (r_state == ST_NEXT) begin
        if (w_found) r_addr <= w_found_addr;
        else r_cfg_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_40 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_table[i] <= DEFAULT_TABLE[i];
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  lupa_spi_frame_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_frame_tx (
    .clock_40  (clock_40),
    .rst_n     (rst_n),
    .load      (w_load),
    .frame     (w_frame),
    .spi_clk   (spi_clk),
    .spi_en    (spi_en),
    .spi_dat   (spi_dat),
    .frame_done(w_frame_done)
  );

endmodule

// File: tb/tb_lupa_cfg_sequencer.sv
// tb/tb_lupa_cfg_sequencer.sv - self-checking bench for lupa_cfg_sequencer against a frame-list model
module tb_lupa_cfg_sequencer;

  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 4;
  localparam int PERIOD  = 1 + 33 * CLK_DIV + GAP_CYC + 1;
  localparam int LIMIT   = 16 * PERIOD + 100;
  localparam logic [11:0] DEF_TAB [16] = '{
    12'h029, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
    12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB
  };
`ifdef LUPA_CFG_DIRTY_ONLY_EN
  localparam bit DIRTY_MODE = 1'b1;
`else
  localparam bit DIRTY_MODE = 1'b0;
`endif

  logic        clock_40 = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic [3:0]  nrg      = 4'd0;
  logic        wr_en    = 1'b0;
  logic [3:0]  wr_addr  = 4'd0;
  logic [11:0] wr_data  = 12'd0;
  logic        spi_clk;
  logic        spi_en;
  logic        spi_dat;
  logic        busy;
  logic        cfg_done;
  logic [3:0]  cur_addr;

  int checks   = 0;
  int failures = 0;

  logic [11:0] m_table [16];
  bit          m_dirty [16];

  logic [15:0] mon_frames [$];
  logic [15:0] mon_sh = '0;
  logic        mon_prev_clk = 1'b0;
  logic        mon_prev_dat = 1'b0;
  int          mon_bits = 0;
  int          mon_rises = 0;
  int          mon_viol = 0;
  int          mon_bad_len = 0;
  int          mon_en_len = 0;

  lupa_cfg_sequencer #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clock_40(clock_40),
    .rst_n   (rst_n),
    .start   (start),
    .nrg     (nrg),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .spi_clk (spi_clk),
    .spi_en  (spi_en),
    .spi_dat (spi_dat),
    .busy    (busy),
    .cfg_done(cfg_done),
    .cur_addr(cur_addr)
  );

  always #5 clock_40 = ~clock_40;

  // Sensor-side view: shift on spi_clk rises while enabled, watch pin discipline and frame length.
  always @(negedge clock_40) begin
    if (!rst_n) begin
      mon_bits     = 0;
      mon_en_len   = 0;
      mon_prev_clk = 1'b0;
      mon_prev_dat = 1'b0;
    end else begin
      if (spi_clk && !mon_prev_clk) begin
        mon_rises++;
        if (!spi_en) begin
          mon_sh = {mon_sh[14:0], spi_dat};
          mon_bits++;
          if (mon_bits == 16) begin
            mon_frames.push_back(mon_sh);
            mon_bits = 0;
          end
        end
      end
      if (spi_clk && (spi_dat !== mon_prev_dat)) mon_viol++;
      if (spi_en && (spi_clk || spi_dat)) mon_viol++;
      if (!spi_en) begin
        mon_en_len++;
      end else begin
        if ((mon_en_len != 0) && (mon_en_len != 33 * CLK_DIV)) mon_bad_len++;
        mon_en_len = 0;
        mon_bits   = 0;
      end
      mon_prev_clk = spi_clk;
      mon_prev_dat = spi_dat;
    end
  end

  task automatic tick();
    @(negedge clock_40);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) begin
      m_table[a] = DEF_TAB[a];
      m_dirty[a] = 1'b0;
    end
  endtask

  task automatic host_write(input int a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    m_table[a] = d;
    m_dirty[a] = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // One upload of 0..n; optional start re-pulses and one mid-run write after wr_at frames.
  task automatic upload(input int n, input bit repulse, input int wr_at, input int wr_a,
                        input logic [11:0] wr_d);
    logic [15:0] exp_q [$];
    int blen;
    int guard;
    bit p3;
    bit p7;
    bit wdone;
    mon_frames.delete();
    mon_viol    = 0;
    mon_bad_len = 0;
    start = 1'b1;
    nrg   = 4'(n);
    tick();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("done_clear", 32'(cfg_done), 32'd0);
    blen  = 1;
    guard = 0;
    p3    = 1'b0;
    p7    = 1'b0;
    wdone = 1'b0;
    while ((busy === 1'b1) && (guard < LIMIT)) begin
      start = 1'b0;
      nrg   = 4'(n);
      if (repulse && !p3 && (mon_frames.size() == 3)) begin
        start = 1'b1;
        nrg   = 4'($urandom_range(15, 0));
        p3    = 1'b1;
      end else if (repulse && !p7 && (mon_frames.size() == 7)) begin
        start = 1'b1;
        nrg   = 4'($urandom_range(15, 0));
        p7    = 1'b1;
      end
      if ((wr_at >= 0) && !wdone && (mon_frames.size() == wr_at)) begin
        wr_en   = 1'b1;
        wr_addr = 4'(wr_a);
        wr_data = wr_d;
        m_table[wr_a] = wr_d;
        m_dirty[wr_a] = 1'b1;
        wdone = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      if (busy === 1'b1) blen++;
      guard++;
    end
    start = 1'b0;
    nrg   = 4'(n);
    check("busy_timeout", 32'(guard < LIMIT), 32'd1);
    for (int a = 0; a <= n; a++) begin
      if (!DIRTY_MODE || m_dirty[a]) begin
        exp_q.push_back({4'(a), m_table[a]});
        m_dirty[a] = 1'b0;
      end
    end
    check("busy_len", 32'(blen), (exp_q.size() == 0) ? 32'd1 : 32'(exp_q.size() * PERIOD));
    check("done_rise", 32'(cfg_done), 32'd1);
    check("frame_count", 32'(mon_frames.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < mon_frames.size()); i++) begin
      check($sformatf("frame_%0d", i), 32'(mon_frames[i]), 32'(exp_q[i]));
    end
    if (exp_q.size() > 0) begin
      check("cur_addr_end", 32'(cur_addr), 32'(exp_q[exp_q.size()-1][15:12]));
    end
    check("pin_discipline", 32'(mon_viol), 32'd0);
    check("frame_length", 32'(mon_bad_len), 32'd0);
  endtask

  initial begin
    int guard;
    int rises;
    model_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_spi_en", 32'(spi_en), 32'd1);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_spi_dat", 32'(spi_dat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_cur_addr", 32'(cur_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    upload(0, 1'b0, -1, 0, 12'h000);
`ifndef LUPA_CFG_DIRTY_ONLY_EN
    if (mon_frames.size() > 0) check("single_frame_bits", 32'(mon_frames[0]), 32'h0029);
`endif
    upload(15, 1'b0, -1, 0, 12'h000);

    host_write(12, 12'hFF0);
    upload(12, 1'b0, -1, 0, 12'h000);
    if (mon_frames.size() > 0) check("addr12_frame", 32'(mon_frames[mon_frames.size()-1]), 32'hCFF0);

    for (int it = 0; it < 3; it++) begin
      int nw;
      nw = $urandom_range(2, 0);
      for (int w = 0; w < nw; w++) host_write($urandom_range(15, 0), 12'($urandom));
      upload($urandom_range(15, 0), 1'b0, -1, 0, 12'h000);
    end

    host_write(1, 12'($urandom));
    upload($urandom_range(15, 8), 1'b1, -1, 0, 12'h000);

    host_write(2, 12'($urandom));
    upload(15, 1'b0, 1, 14, 12'($urandom));

    for (int a = 0; a < 16; a++) host_write(a, 12'($urandom));
    mon_frames.delete();
    start = 1'b1;
    nrg   = 4'd15;
    tick();
    start = 1'b0;
    guard = 0;
    while (!((mon_frames.size() == 2) && (mon_bits == 5)) && (guard < LIMIT)) begin
      tick();
      guard++;
    end
    check("abort_reached", 32'(guard < LIMIT), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_spi_en", 32'(spi_en), 32'd1);
    check("abort_spi_clk", 32'(spi_clk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rises = mon_rises;
    rst_n = 1'b1;
    model_reset();
    repeat (20) tick();
    check("abort_no_resume", 32'(mon_rises), 32'(rises));
    check("abort_idle_en", 32'(spi_en), 32'd1);
    check("abort_idle_busy", 32'(busy), 32'd0);

    upload(15, 1'b0, -1, 0, 12'h000);

    host_write(3, 12'($urandom));
    host_write(9, 12'($urandom));
    upload(15, 1'b0, -1, 0, 12'h000);
    upload(15, 1'b0, -1, 0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
